// File: rtl/piso_bitorder.sv
// piso_bitorder: parallel-in/serial-out shifter with per-word selectable bit order.
// A word is captured on the input handshake together with its bit-order mode,
// then presented one bit per accepted serial beat. The last beat of a word can
// accept the next word, so back-to-back words stream with no idle cycle.
module piso_bitorder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               m_q, m_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_shift;
    logic               is_last;
    logic               beat;
    logic               accept;
    logic [WIDTH-1:0]   sh_shifted;

    assign in_shift = (state_q == SHIFT);
    assign is_last  = in_shift && (idx_q == IDX_LAST);
    assign beat     = in_shift && ser_ready;

    // The completing beat frees the register, so ready follows ser_ready there.
    assign in_ready = !in_shift || (beat && is_last);
    assign accept   = in_valid && in_ready;

    // Shift toward the output end chosen by the captured mode, zero-filled.
    assign sh_shifted = m_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    // Next-state selection: load on accept, advance on a non-final beat,
    // otherwise hold everything (stall or idle).
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        m_d     = m_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (beat && is_last) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
            sh_d    = '0;
            idx_d   = '0;
        end else if (beat) begin
            sh_d  = sh_shifted;
            idx_d = idx_q + IDX_W'(1);
        end
        if (accept) begin
            state_d = SHIFT;
            sh_d    = in_data;
            m_d     = in_msb_first;
            idx_d   = '0;
        end
    end

    // State registers; reset drops any word in flight without counting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            m_q     <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial outputs come directly from register bits.
    assign ser_valid  = in_shift;
    assign busy       = in_shift;
    assign ser_out    = m_q ? sh_q[WIDTH-1] : sh_q[0];
    assign ser_last   = is_last;
    assign words_done = cnt_q;

endmodule

// File: tb/tb_piso_bitorder.sv
// Bench for piso_bitorder: a queue-based model of the serial stream checked
// every cycle, directed words pinned to literal bit sequences, then random traffic.
// A second instance with a 2-bit counter shares the stimulus to exercise wrap.
module tb_piso_bitorder;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [W-1:0] in_data;
    logic       in_msb_first;
    logic       ser_ready;

    logic       in_ready_a, ser_valid_a, ser_out_a, ser_last_a, busy_a;
    logic [7:0] words_done_a;
    logic       in_ready_b, ser_valid_b, ser_out_b, ser_last_b, busy_b;
    logic [1:0] words_done_b;

    int total = 0;
    int bad   = 0;

    // Model state: bits still owed for the current word (front = on the wire now).
    bit         exp_q[$];
    int         exp_cnt = 0;
    bit         obs_q[$];

    always #5 clk = ~clk;

    piso_bitorder #(.WIDTH(W), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .in_msb_first(in_msb_first),
        .ser_valid(ser_valid_a), .ser_ready(ser_ready), .ser_out(ser_out_a),
        .ser_last(ser_last_a), .busy(busy_a), .words_done(words_done_a)
    );

    piso_bitorder #(.WIDTH(W), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_msb_first(in_msb_first),
        .ser_valid(ser_valid_b), .ser_ready(ser_ready), .ser_out(ser_out_b),
        .ser_last(ser_last_b), .busy(busy_b), .words_done(words_done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the
    // coming rising edge using the inputs that are now stable.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_valid, exp_rdy;
            exp_valid = (exp_q.size() != 0);
            exp_rdy   = !exp_valid || (ser_ready && exp_q.size() == 1);
            chk("in_ready", in_ready_a, exp_rdy);
            chk("ser_valid", ser_valid_a, exp_valid);
            chk("busy", busy_a, exp_valid);
            chk("words_done", words_done_a, exp_cnt % 256);
            chk("words_done_w2", words_done_b, exp_cnt % 4);
            chk("ser_valid_w2", ser_valid_b, exp_valid);
            if (exp_valid) begin
                chk("ser_out", ser_out_a, exp_q[0]);
                chk("ser_last", ser_last_a, exp_q.size() == 1);
                chk("ser_out_w2", ser_out_b, exp_q[0]);
            end
            if (ser_valid_a && ser_ready)
                obs_q.push_back(ser_out_a);
            if (exp_valid && ser_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0)
                    exp_cnt++;
            end
            if (in_valid && exp_rdy) begin
                for (int i = 0; i < W; i++)
                    exp_q.push_back(in_msb_first ? in_data[W-1-i] : in_data[i]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", in_ready_a, 1'b1);
        chk("rst_ser_valid", ser_valid_a, 1'b0);
        chk("rst_ser_out", ser_out_a, 1'b0);
        chk("rst_ser_last", ser_last_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_words_done", words_done_a, 8'd0);
        chk("rst_words_done_w2", words_done_b, 2'd0);
    endtask

    // Called just after a rising edge: asserts reset mid-cycle.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        check_reset_values();
        #10;
        rst_n = 1'b1;
        cyc();
    endtask

    // Present a word and hold it until the design takes it; in_valid is left high.
    task automatic push_word(input logic [W-1:0] d, input logic msb);
        bit acc;
        int n;
        in_valid     = 1'b1;
        in_data      = d;
        in_msb_first = msb;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready_a;
            cyc();
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        $display("word accepted data=%02h msb_first=%0d", d, msb);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            cyc();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_seq(input string nm, input logic [15:0] seq, input int len);
        logic [15:0] got;
        got = '0;
        chk({nm, "_len"}, obs_q.size(), len);
        for (int i = 0; i < len && i < obs_q.size(); i++)
            got[len-1-i] = obs_q[i];
        chk(nm, got, seq);
        $display("stream %s observed %0d bits", nm, obs_q.size());
        obs_q.delete();
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_msb_first = 1'b0;
        ser_ready = 1'b1;
        #4;
        check_reset_values();
        #8;
        rst_n = 1'b1;
        cyc();

        // 0xF5 both orders.
        obs_q.delete();
        push_word(8'hF5, 1'b1);
        in_valid = 1'b0;
        drain();
        check_seq("f5_msb", 16'b11110101, 8);
        chk("cnt_after_f5_msb", words_done_a, 8'd1);

        push_word(8'hF5, 1'b0);
        in_valid = 1'b0;
        drain();
        check_seq("f5_lsb", 16'b10101111, 8);
        chk("cnt_after_f5_lsb", words_done_a, 8'd2);

        // 0xA5 with a 3-cycle consumer stall on the third bit.
        push_word(8'hA5, 1'b1);
        in_valid = 1'b0;
        in_msb_first = 1'b0;   // mode change mid-word must not matter
        cyc();
        cyc();
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_ser_out", ser_out_a, 1'b1);
            chk("stall_ser_valid", ser_valid_a, 1'b1);
        end
        ser_ready = 1'b1;
        drain();
        check_seq("a5_stall", 16'b10100101, 8);
        chk("cnt_after_a5", words_done_a, 8'd3);

        // Back-to-back words with in_valid held.
        push_word(8'h01, 1'b0);
        push_word(8'h80, 1'b1);
        in_valid = 1'b0;
        drain();
        check_seq("b2b", 16'b1000000010000000, 16);
        chk("cnt_after_b2b", words_done_a, 8'd5);

        // Mid-word asynchronous reset, then a fresh word.
        push_word(8'hFF, 1'b1);
        in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        do_reset();
        obs_q.delete();
        push_word(8'hC3, 1'b1);
        in_valid = 1'b0;
        drain();
        check_seq("after_reset", 16'b11000011, 8);
        chk("cnt_after_reset", words_done_a, 8'd1);

        // Counter wrap on the 2-bit instance.
        cyc();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_word(W'($urandom), 1'($urandom));
            in_valid = 1'b0;
            drain();
            chk("wrap_cnt", words_done_b, wrap_exp[k]);
        end
        obs_q.delete();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid     = ($urandom_range(0, 2) != 0);
            in_data      = W'($urandom);
            in_msb_first = 1'($urandom);
            ser_ready    = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        drain();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_bitorder.md
Name: piso_bitorder

Overview:
- Parametrised parallel-in/serial-out shifter with a run-time selectable bit order (MSB-first or LSB-first), captured per word.
- Sits between word-wide producers and single-bit serial consumers.
- Valid/ready handshake on both sides, with back-to-back word support.
- Keeps a wrapping count of completed words for debug and bench checking.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
CNT_W, 8, width of the completed-word counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  producer presents a word.
in_ready  output  1  block can accept a word this cycle.
in_data  input  WIDTH  parallel word; sampled on accept.
in_msb_first  input  1  bit-order mode (1 = MSB first, 0 = LSB first); sampled on accept.
ser_valid  output  1  ser_out carries a valid bit.
ser_ready  input  1  consumer accepts the current bit.
ser_out  output  1  current serial bit.
ser_last  output  1  current bit is the final bit of the word.
busy  output  1  a word is being shifted.
words_done  output  CNT_W  count of completed words; wraps modulo 2^CNT_W.

Behaviour:
Reset:
- rst_n low asynchronously forces state to IDLE.
- Shift register, index and words_done are cleared to 0.
- Any word in flight is discarded with no partial completion.
- Reset values: in_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0, words_done=0.

FSM states: IDLE and SHIFT.

IDLE:
- in_ready=1, ser_valid=0, busy=0.
- On in_valid=1: capture in_data into shift register sh, capture in_msb_first into mode register m, set idx=0, go to SHIFT.
- First bit appears on ser_out the next cycle, so accept-to-first-bit latency is 1 cycle.

SHIFT:
- ser_valid=1, busy=1.
- ser_out = sh[WIDTH-1] when m=1; ser_out = sh[0] when m=0. ser_out comes straight from a register bit, with no combinational path from inputs.
- ser_last = (idx == WIDTH-1).
- On ser_ready=1 and ser_last=0: shift sh toward the output end (left when m=1, right when m=0, zero-filled) and increment idx.
- On ser_ready=0: hold sh, idx, ser_out and ser_last stable. ser_valid stays 1 and must not drop.
- On ser_ready=1 and ser_last=1, the word completes:
  - words_done increments by 1, wrapping at 2^CNT_W with no saturation.
  - in_ready=1 in this same cycle (combinational on ser_ready).
  - If in_valid=1 as well, the new word and mode are captured, idx=0 and state stays SHIFT. There is no idle bubble: bit 0 of the new word is on ser_out next cycle.
  - If in_valid=0, go to IDLE.

Handshake and edge cases:
- in_ready=0 during SHIFT except on the completing beat. in_data and in_msb_first are ignored when not accepted.
- Changing in_msb_first mid-word has no effect on the word in flight.
- A word takes exactly WIDTH accepted serial beats; the minimum is WIDTH cycles per word back-to-back.
- idx width is clog2(WIDTH); idx never exceeds WIDTH-1.

Test Plan:
- Reset, then load 8'hF5 (8'b11110101) with msb_first=1 and ser_ready held 1 -> ser_out sequence 1,1,1,1,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; ser_last=1 only on the 8th bit; words_done=1.
- Same word with msb_first=0 -> sequence 1,0,1,0,1,1,1,1; ser_last on the 8th bit; words_done=2.
- Load 8'hA5 (msb_first=1) with ser_ready deasserted for 3 cycles after bit 2 -> ser_out=1 and ser_valid=1 held stable during the stall; full sequence 1,0,1,0,0,1,0,1 delivered; no bit lost or duplicated.
- Back-to-back: in_valid held 1 with 8'h01 (msb_first=0) then 8'h80 (msb_first=1) -> 16 contiguous valid beats 1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0; in_ready high only on beat 8; busy never drops; words_done +2.
- Assert rst_n=0 asynchronously (mid-cycle) during bit 4 of 8'hFF -> outputs return to reset values immediately; words_done=0; after release, a fresh word serialises correctly from bit 0.
- CNT_W=2 build, 5 words sent -> words_done reads 1,2,3,0,1 after each completion.
